// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the projectCPU2021 memory responder.
package cpu_mem_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 16;
   localparam int LAST_ADDR  = 8191;

   typedef enum logic {
      LOAD,
      RUN
   } mem_state_t;

endpackage

// File: rtl/cpu_mem_responder_resp_bram.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
module resp_bram
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] dout_q;

   // Read samples the array before the write lands, giving old data on a collision.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
      dout_q <= mem_q[addr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Boot-loading memory responder for the projectCPU2021 memory port.
// Optional CPU write protection below PROT_LIMIT is enabled by defining CPU_MEM_WPROT_EN.
module cpu_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int BOOT_LOAD  = 1,
   parameter int PROT_LIMIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] addr_toRAM,
   input  logic [DATA_W-1:0] data_toRAM,
   output logic [DATA_W-1:0] data_fromRAM,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              cpu_rst,
   output logic [ADDR_W-1:0] load_count,
   output logic              wprot_err
);

   localparam logic [ADDR_W-1:0] LAST        = ADDR_W'(LAST_ADDR);
   localparam mem_state_t        RESET_STATE = (BOOT_LOAD != 0) ? LOAD : RUN;

   mem_state_t        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ld_ready_q, ld_ready_d;
   logic              rd_en_q, rd_en_d;
   logic              handshake;
   logic              cpu_we;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   assign handshake = rst && (state_q == LOAD) && ld_ready_q && ld_valid;

`ifdef CPU_MEM_WPROT_EN
   logic wprot_err_q, wprot_err_d;
   logic prot_hit;

   assign prot_hit = rst && (state_q == RUN) && wrEn &&
                     ({1'b0, addr_toRAM} < (ADDR_W+1)'(PROT_LIMIT));
   assign cpu_we   = rst && (state_q == RUN) && wrEn && !prot_hit;

   always_comb begin
      wprot_err_d = wprot_err_q | prot_hit;
      if (!rst) begin
         wprot_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      wprot_err_q <= wprot_err_d;
   end

   assign wprot_err = wprot_err_q;
`else
   logic unused_prot;

   assign unused_prot = ^(ADDR_W'(PROT_LIMIT));
   assign cpu_we      = rst && (state_q == RUN) && wrEn;
   assign wprot_err   = 1'b0;
`endif

   // The pointer saturates on the final address so it doubles as load_count.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      ld_ready_d = 1'b0;
      rd_en_d    = 1'b0;
      if (!rst) begin
         state_d = RESET_STATE;
         ptr_d   = '0;
      end else begin
         if (handshake) begin
            if (ld_last || (ptr_q == LAST)) begin
               state_d = RUN;
            end
            if (ptr_q != LAST) begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ld_ready_d = (state_d == LOAD);
         rd_en_d    = (state_q == RUN);
      end
   end

   always_ff @(posedge clk) begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ld_ready_q <= ld_ready_d;
      rd_en_q    <= rd_en_d;
   end

   assign ram_we   = handshake | cpu_we;
   assign ram_addr = (state_q == LOAD) ? ptr_q : addr_toRAM;
   assign ram_din  = (state_q == LOAD) ? ld_data : data_toRAM;

   resp_bram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   // Read data is only exposed for reads issued while already in RUN.
   assign data_fromRAM = rd_en_q ? ram_dout : '0;
   assign ld_ready     = ld_ready_q;
   assign load_count   = ptr_q;
   assign cpu_rst      = (state_q == LOAD) || (!rst && (BOOT_LOAD != 0));

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: boot load, CPU read/write, resets, protection.
module tb_cpu_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrEn;
   logic [12:0] addr_toRAM;
   logic [15:0] data_toRAM;
   logic [15:0] data_fromRAM;
   logic        ld_valid;
   logic        ld_ready;
   logic [15:0] ld_data;
   logic        ld_last;
   logic        cpu_rst;
   logic [12:0] load_count;
   logic        wprot_err;
   logic        rd_req;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] mon_exp;

   cpu_mem_responder #(
      .ADDR_W     (13),
      .DATA_W     (16),
      .BOOT_LOAD  (1),
      .PROT_LIMIT (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wrEn         (wrEn),
      .addr_toRAM   (addr_toRAM),
      .data_toRAM   (data_toRAM),
      .data_fromRAM (data_fromRAM),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .cpu_rst      (cpu_rst),
      .load_count   (load_count),
      .wprot_err    (wprot_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Inputs change on the falling edge; a read request queues its expected data.
   task automatic applyStimulus(input logic r, input logic we, input logic [12:0] a,
                                input logic [15:0] d, input logic lv, input logic [15:0] ldd,
                                input logic ll, input logic rq, input logic [15:0] rexp);
      @(negedge clk);
      rst        = r;
      wrEn       = we;
      addr_toRAM = a;
      data_toRAM = d;
      ld_valid   = lv;
      ld_data    = ldd;
      ld_last    = ll;
      rd_req     = rq;
      if (rq) exp_q.push_back(rexp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic r, input int n);
      repeat (n) applyStimulus(r, 1'b0, 13'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic loadWord(input logic [15:0] d, input logic last);
      applyStimulus(1'b1, 1'b0, 13'd0, 16'h0, 1'b1, d, last, 1'b0, 16'h0);
   endtask

   task automatic cpuRead(input logic [12:0] a, input logic [15:0] e);
      applyStimulus(1'b1, 1'b0, a, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, e);
   endtask

   task automatic cpuWrite(input logic [12:0] a, input logic [15:0] d);
      applyStimulus(1'b1, 1'b1, a, d, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic cpuRdWr(input logic [12:0] a, input logic [15:0] d, input logic [15:0] e);
      applyStimulus(1'b1, 1'b1, a, d, 1'b0, 16'h0, 1'b0, 1'b1, e);
   endtask

   // Read data appears one edge after the request is sampled.
   always @(posedge clk) begin
      if (rd_req) begin
         #1;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL rd_data: got %0h expected none queued", data_fromRAM);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("rd_data", {16'h0, data_fromRAM}, {16'h0, mon_exp});
         end
      end
   end

   initial begin
      rst        = 1'b0;
      wrEn       = 1'b0;
      addr_toRAM = '0;
      data_toRAM = '0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      ld_last    = 1'b0;
      rd_req     = 1'b0;

      $display("[TB] reset with ld_valid held high");
      applyStimulus(1'b0, 1'b0, 13'd0, 16'h0, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 13'd0, 16'h0, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0);
      checkOutput("rst_ld_ready", ld_ready, 0);
      checkOutput("rst_cpu_rst", cpu_rst, 1);
      checkOutput("rst_load_count", load_count, 0);
      checkOutput("rst_data", data_fromRAM, 0);
      checkOutput("rst_wprot", wprot_err, 0);

      applyStimulus(1'b1, 1'b0, 13'd0, 16'h0, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0);
      checkOutput("release_ld_ready", ld_ready, 1);
      checkOutput("release_no_accept", load_count, 0);

      $display("[TB] boot load with a 3-cycle gap");
      loadWord(16'h0003, 1'b0);
      loadWord(16'h1234, 1'b0);
      checkOutput("load_count_2", load_count, 2);
      repeat (3) applyStimulus(1'b1, 1'b0, 13'd0, 16'h0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h0);
      checkOutput("gap_load_count", load_count, 2);
      checkOutput("gap_cpu_rst", cpu_rst, 1);
      checkOutput("gap_ld_ready", ld_ready, 1);
      loadWord(16'hBEEF, 1'b0);
      checkOutput("pre_last_cpu_rst", cpu_rst, 1);
      checkOutput("load_count_3", load_count, 3);
      checkOutput("load_data_zero", data_fromRAM, 0);
      loadWord(16'h0000, 1'b1);
      checkOutput("last_cpu_rst", cpu_rst, 0);
      checkOutput("last_ld_ready", ld_ready, 0);
      checkOutput("load_count_4", load_count, 4);
      checkOutput("run_entry_data", data_fromRAM, 0);

      $display("[TB] run-mode reads and writes");
      cpuRead(13'd2, 16'hBEEF);
      cpuRead(13'd0, 16'h0003);
      cpuRead(13'd1, 16'h1234);
      cpuRead(13'd3, 16'h0000);
      cpuWrite(13'd147, 16'hDEAF);
      cpuRead(13'd147, 16'hDEAF);
      cpuWrite(13'd72, 16'h00FF);
      cpuRdWr(13'd72, 16'h0007, 16'h00FF);
      cpuRead(13'd72, 16'h0007);
      checkOutput("run_load_count", load_count, 4);

      $display("[TB] reset during run");
      @(negedge clk);
      rst      = 1'b0;
      rd_req   = 1'b0;
      wrEn     = 1'b0;
      ld_valid = 1'b0;
      #1;
      checkOutput("run_rst_cpu_rst", cpu_rst, 1);
      @(posedge clk);
      #1;
      checkOutput("run_rst_data", data_fromRAM, 0);
      checkOutput("run_rst_ld_ready", ld_ready, 0);
      checkOutput("run_rst_load_count", load_count, 0);
      idle(1'b1, 1);
      checkOutput("reload_ld_ready", ld_ready, 1);

      $display("[TB] full 8192-word load without ld_last");
      for (int i = 0; i < 8192; i++) begin
         loadWord(16'h1000 + 16'(i), 1'b0);
         if (i == 8190) begin
            checkOutput("full_pre_cpu_rst", cpu_rst, 1);
            checkOutput("full_pre_count", load_count, 8191);
         end
      end
      checkOutput("full_cpu_rst", cpu_rst, 0);
      checkOutput("full_ld_ready", ld_ready, 0);
      checkOutput("full_load_count", load_count, 8191);
      repeat (3) applyStimulus(1'b1, 1'b0, 13'd0, 16'h0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0);
      checkOutput("full_count_held", load_count, 8191);
      cpuRead(13'd0, 16'h1000);
      cpuRead(13'd8191, 16'h2FFF);
      cpuRead(13'd5, 16'h1005);

      $display("[TB] write protection");
      cpuWrite(13'd5, 16'hDEAD);
`ifdef CPU_MEM_WPROT_EN
      checkOutput("wprot_set", wprot_err, 1);
`else
      checkOutput("wprot_tied", wprot_err, 0);
`endif
      cpuWrite(13'd16, 16'hCAFE);
`ifdef CPU_MEM_WPROT_EN
      cpuRead(13'd5, 16'h1005);
      cpuRead(13'd16, 16'hCAFE);
      checkOutput("wprot_sticky", wprot_err, 1);
`else
      cpuRead(13'd5, 16'hDEAD);
      cpuRead(13'd16, 16'hCAFE);
      checkOutput("wprot_still_0", wprot_err, 0);
`endif

      $display("[TB] reset during load");
      idle(1'b0, 1);
      idle(1'b1, 1);
      loadWord(16'h7777, 1'b0);
      loadWord(16'h8888, 1'b0);
      checkOutput("midload_count", load_count, 2);
      idle(1'b0, 1);
      checkOutput("midload_rst_count", load_count, 0);
      checkOutput("midload_rst_ready", ld_ready, 0);
      checkOutput("midload_rst_cpu", cpu_rst, 1);
      checkOutput("midload_rst_wprot", wprot_err, 0);
      idle(1'b1, 1);
      loadWord(16'hAAAA, 1'b1);
      checkOutput("reload_count", load_count, 1);
      checkOutput("reload_cpu_rst", cpu_rst, 0);
      cpuRead(13'd0, 16'hAAAA);
      cpuRead(13'd1, 16'h8888);

      idle(1'b1, 2);
      checkOutput("scoreboard_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
